// File: rtl/mem_access_stage.sv
// mem_access_stage: MEM-stage controller running loads/stores as req/ack transactions with stall, misalign and timeout handling
module mem_access_stage #(
  parameter int DATA_W      = 32,
  parameter int RADDR_W     = 5,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               Regfile_weM,
  input  logic               DataMem_weM,
  input  logic               MemToRegM,
  input  logic [RADDR_W-1:0] wirteRegAddrM,
  input  logic [DATA_W-1:0]  aluOutM,
  input  logic [DATA_W-1:0]  writeDataM,
  output logic               stallM,
  output logic               dmem_req,
  output logic               dmem_we,
  output logic [DATA_W-1:0]  dmem_addr,
  output logic [DATA_W-1:0]  dmem_wdata,
  input  logic               dmem_ack,
  input  logic [DATA_W-1:0]  dmem_rdata,
  output logic               Regfile_weW,
  output logic [RADDR_W-1:0] wirteRegAddrW,
  output logic [DATA_W-1:0]  resultW,
  output logic               excW
);
  localparam int CW = $clog2(TIMEOUT_CYC);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYC - 1);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t state, nextState;
  logic [CW-1:0] cnt;
  logic memOp, aligned, timeout, isLoad, weLatched, errFlag;
  logic [RADDR_W-1:0] destReg;
  logic [DATA_W-1:0] rdataLatched;
  assign memOp   = DataMem_weM | MemToRegM;
  assign aligned = aluOutM[1:0] == 2'b00;
  assign timeout = cnt == LAST;
  always_comb begin
    nextState = state == IDLE ? (memOp && aligned ? WAIT : IDLE) :
                state == WAIT ? (dmem_ack || timeout ? RESP : WAIT) : IDLE;
    stallM    = rst && ((state == IDLE && memOp && aligned) || state == WAIT);
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else      state <= nextState;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      cnt           <= '0;
      dmem_req      <= 1'b0;
      dmem_we       <= 1'b0;
      dmem_addr     <= '0;
      dmem_wdata    <= '0;
      isLoad        <= 1'b0;
      weLatched     <= 1'b0;
      errFlag       <= 1'b0;
      destReg       <= '0;
      rdataLatched  <= '0;
      Regfile_weW   <= 1'b0;
      wirteRegAddrW <= '0;
      resultW       <= '0;
      excW          <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          cnt <= '0;
          if (memOp && aligned) begin
            dmem_req    <= 1'b1;
            dmem_we     <= DataMem_weM;
            dmem_addr   <= aluOutM;
            dmem_wdata  <= writeDataM;
            isLoad      <= MemToRegM;
            weLatched   <= Regfile_weM;
            destReg     <= wirteRegAddrM;
            errFlag     <= 1'b0;
            Regfile_weW <= 1'b0;
            excW        <= 1'b0;
          end else begin
            Regfile_weW   <= memOp ? 1'b0 : Regfile_weM;
            excW          <= memOp;
            wirteRegAddrW <= wirteRegAddrM;
            resultW       <= aluOutM;
          end
        end
        WAIT: begin
          cnt <= cnt + 1'b1;
          // ack takes priority over a coincident timeout
          if (dmem_ack) begin
            rdataLatched <= dmem_rdata;
            dmem_req     <= 1'b0;
          end else if (timeout) begin
            dmem_req <= 1'b0;
            errFlag  <= 1'b1;
          end
        end
        RESP: begin
          wirteRegAddrW <= destReg;
          Regfile_weW   <= !errFlag && isLoad && weLatched;
          excW          <= errFlag;
          if (!errFlag && isLoad) resultW <= rdataLatched;
        end
        default: ;
      endcase
    end
endmodule

// File: tb/tb_mem_access_stage.sv
// tb_mem_access_stage: directed checks of ALU pass-through, load/store handshakes, misalign, timeout and async reset
module tb_mem_access_stage;
  logic clk = 1'b0, rst = 1'b0;
  logic Regfile_weM = 0, DataMem_weM = 0, MemToRegM = 0;
  logic [4:0] wirteRegAddrM = 0;
  logic [31:0] aluOutM = 0, writeDataM = 0;
  logic stallM, dmem_req, dmem_we, dmem_ack = 0;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata = 0;
  logic Regfile_weW, excW;
  logic [4:0] wirteRegAddrW;
  logic [31:0] resultW;
  int total = 0, bad = 0;

  mem_access_stage #(.DATA_W(32), .RADDR_W(5), .TIMEOUT_CYC(4)) dut (
    .clk(clk), .rst(rst),
    .Regfile_weM(Regfile_weM), .DataMem_weM(DataMem_weM), .MemToRegM(MemToRegM),
    .wirteRegAddrM(wirteRegAddrM), .aluOutM(aluOutM), .writeDataM(writeDataM),
    .stallM(stallM), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .Regfile_weW(Regfile_weW), .wirteRegAddrW(wirteRegAddrW),
    .resultW(resultW), .excW(excW)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s got=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic rwe, input logic dwe, input logic mtr,
                       input logic [4:0] rd, input logic [31:0] alu, input logic [31:0] wd);
    Regfile_weM = rwe; DataMem_weM = dwe; MemToRegM = mtr;
    wirteRegAddrM = rd; aluOutM = alu; writeDataM = wd;
    #1;
  endtask

  initial begin
    cyc; cyc;
    chk("rst_stall", stallM, 0);
    chk("rst_req", dmem_req, 0);
    chk("rst_weW", Regfile_weW, 0);
    chk("rst_addrW", wirteRegAddrW, 0);
    chk("rst_resW", resultW, 0);
    chk("rst_exc", excW, 0);
    rst = 1'b1;
    // ALU op
    drive(1, 0, 0, 5, 32'h1234, 0);
    chk("alu_stall", stallM, 0);
    cyc;
    chk("alu_weW", Regfile_weW, 1);
    chk("alu_addrW", wirteRegAddrW, 5);
    chk("alu_resW", resultW, 32'h1234);
    chk("alu_stall2", stallM, 0);
    drive(0, 0, 0, 0, 0, 0);
    // load 0x100, ack in first WAIT cycle
    drive(1, 0, 1, 7, 32'h100, 0);
    chk("ld_stall0", stallM, 1);
    chk("ld_req0", dmem_req, 0);
    cyc;
    chk("ld_req1", dmem_req, 1);
    chk("ld_we", dmem_we, 0);
    chk("ld_addr", dmem_addr, 32'h100);
    chk("ld_stall1", stallM, 1);
    chk("ld_bubble", Regfile_weW, 0);
    dmem_ack = 1; dmem_rdata = 32'hDEADBEEF;
    cyc;
    dmem_ack = 0; dmem_rdata = 0;
    chk("ld_req_resp", dmem_req, 0);
    chk("ld_stall_resp", stallM, 0);
    chk("ld_weW_resp", Regfile_weW, 0);
    cyc;
    chk("ld_weW", Regfile_weW, 1);
    chk("ld_addrW", wirteRegAddrW, 7);
    chk("ld_resW", resultW, 32'hDEADBEEF);
    chk("ld_exc", excW, 0);
    drive(0, 0, 0, 0, 0, 0);
    // store 0x40, ack on third WAIT cycle
    drive(0, 1, 0, 3, 32'h40, 32'hA5A5A5A5);
    chk("st_stall0", stallM, 1);
    for (int i = 0; i < 3; i++) begin
      cyc;
      chk("st_req", dmem_req, 1);
      chk("st_we", dmem_we, 1);
      chk("st_addr", dmem_addr, 32'h40);
      chk("st_wdata", dmem_wdata, 32'hA5A5A5A5);
      chk("st_stall", stallM, 1);
    end
    dmem_ack = 1;
    cyc;
    dmem_ack = 0;
    chk("st_req_resp", dmem_req, 0);
    chk("st_stall_resp", stallM, 0);
    cyc;
    chk("st_weW", Regfile_weW, 0);
    chk("st_exc", excW, 0);
    drive(0, 0, 0, 0, 0, 0);
    // misaligned load
    drive(1, 0, 1, 9, 32'h102, 0);
    chk("mis_stall", stallM, 0);
    cyc;
    chk("mis_req", dmem_req, 0);
    chk("mis_exc", excW, 1);
    chk("mis_weW", Regfile_weW, 0);
    drive(0, 0, 0, 0, 0, 0);
    cyc;
    chk("mis_exc_pulse", excW, 0);
    // load timeout
    drive(1, 0, 1, 4, 32'h200, 0);
    for (int i = 0; i < 4; i++) begin
      cyc;
      chk("to_req", dmem_req, 1);
      chk("to_stall", stallM, 1);
    end
    cyc;
    chk("to_req_resp", dmem_req, 0);
    chk("to_exc_resp", excW, 0);
    chk("to_stall_resp", stallM, 0);
    cyc;
    chk("to_exc", excW, 1);
    chk("to_weW", Regfile_weW, 0);
    drive(0, 0, 0, 0, 0, 0);
    cyc;
    chk("to_exc_pulse", excW, 0);
    chk("to_idle_stall", stallM, 0);
    // ack on the timeout cycle wins
    drive(1, 0, 1, 6, 32'h204, 0);
    for (int i = 0; i < 4; i++) begin
      cyc;
      chk("tw_req", dmem_req, 1);
    end
    dmem_ack = 1; dmem_rdata = 32'h55AA;
    cyc;
    dmem_ack = 0; dmem_rdata = 0;
    chk("tw_req_resp", dmem_req, 0);
    cyc;
    chk("tw_exc", excW, 0);
    chk("tw_weW", Regfile_weW, 1);
    chk("tw_resW", resultW, 32'h55AA);
    drive(0, 0, 0, 0, 0, 0);
    // async reset during WAIT
    drive(1, 0, 1, 2, 32'h300, 0);
    cyc;
    chk("ar_req_wait", dmem_req, 1);
    #2 rst = 1'b0;
    #1;
    chk("ar_req", dmem_req, 0);
    chk("ar_stall", stallM, 0);
    chk("ar_weW", Regfile_weW, 0);
    @(posedge clk);
    #1 rst = 1'b1;
    drive(1, 0, 0, 11, 32'hCAFE, 0);
    dmem_ack = 1; dmem_rdata = 32'hFFFF0000;
    chk("ar_alu_stall", stallM, 0);
    cyc;
    dmem_ack = 0;
    chk("ar_alu_weW", Regfile_weW, 1);
    chk("ar_alu_addrW", wirteRegAddrW, 11);
    chk("ar_alu_resW", resultW, 32'hCAFE);
    chk("ar_stray_req", dmem_req, 0);
    chk("ar_stray_stall", stallM, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
